// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misalign check is enabled by defining IFETCH_MISALIGN_CHK_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RST_PC      = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory and decode handshake bundle of the fetch stage.
// Optional misalign check is enabled by defining IFETCH_MISALIGN_CHK_EN.
interface ifetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        id_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i,
        output inst_o,
        output inst_pc_o,
        output inst_valid_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i,
        input  inst_o,
        input  inst_pc_o,
        input  inst_valid_o,
        output id_ready_i
    );

endinterface

// File: rtl/ifetch_wdt.sv
// Fetch timeout counter: counts request cycles without ack, saturating.
// Optional misalign check is enabled by defining IFETCH_MISALIGN_CHK_EN.
module ifetch_wdt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == LAST);

    // Count unanswered request cycles; hold at LAST so it never wraps.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC -> imem req/ack -> held instruction for decode.
// Optional misalign check is enabled by defining IFETCH_MISALIGN_CHK_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INST       = NOP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic        pc_en_o,
    ifetch_if.master    bus,
    output logic        bus_err_o,
    output logic        misalign_o
);

    ifetch_state_t state;

    logic        misaligned;
    logic        ack_hit;
    logic        expired;
    logic        wdt_clear;
    logic        wdt_count;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        valid_q;
    logic        err_q;
    logic        mis_q;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misaligned = (state == REQ) && (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign ack_hit   = (state == REQ) && !misaligned && bus.imem_ack_i;
    assign wdt_count = (state == REQ) && !misaligned && !ack_hit;
    assign wdt_clear = !wdt_count;

    assign bus.imem_req_o   = (state == REQ) && !misaligned;
    assign bus.imem_addr_o  = {pc_i[31:2], 2'b00};
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.inst_valid_o = valid_q;
    assign bus_err_o        = err_q;
    assign misalign_o       = mis_q;

    assign pc_en_o = (state == BOOT)
                   || ((state == FULL) && bus.id_ready_i);

    ifetch_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .clear  (wdt_clear),
        .count  (wdt_count),
        .expired(expired)
    );

    // Fetch FSM with the held instruction and status registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= REQ;
                end
                REQ: begin
                    if (misaligned) begin
                        inst_q    <= NOP_INST;
                        inst_pc_q <= pc_i;
                        mis_q     <= 1'b1;
                        valid_q   <= 1'b1;
                        state     <= FULL;
                    end else if (ack_hit) begin
                        inst_q    <= bus.imem_rdata_i;
                        inst_pc_q <= pc_i;
                        mis_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= FULL;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end
                end
                FULL: begin
                    if (bus.id_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= REQ;
                    end
                end
                ERR: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a PC-register model.
// Misalign expectations follow IFETCH_MISALIGN_CHK_EN.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        bus_err;
    logic        misalign;

    int passed;
    int total;

    ifetch_if bus ();

    ifetch_unit #(
        .TIMEOUT_CYCLES(16),
        .NOP_INST      (32'h0000_0013)
    ) dut (
        .clk_i     (clk),
        .rst_n     (rst_n),
        .pc_i      (pc),
        .pc_en_o   (pc_en),
        .bus       (bus.master),
        .bus_err_o (bus_err),
        .misalign_o(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register stage model: reset value, +4 on enable, test override load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RST_PC;
        else if (pc_load) pc <= pc_load_val;
        else if (pc_en) pc <= pc + 32'd4;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_ack_i = 1'b0;
        bus.imem_rdata_i = 32'h0;
        bus.id_ready_i = 1'b0;
        pc_load = 1'b0;
        pc_load_val = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.imem_req_o, bus.inst_valid_o, bus_err, misalign} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b want=0000",
                     {bus.imem_req_o, bus.inst_valid_o, bus_err, misalign});
        end else passed++;
        total++;
        if ({bus.inst_o, bus.inst_pc_o} !== {32'h0000_0013, 32'h0}) begin
            $display("FAIL reset_inst got=%h/%h want=00000013/00000000",
                     bus.inst_o, bus.inst_pc_o);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({pc_en, bus.imem_req_o} !== 2'b10) begin
            $display("FAIL boot_pc_en got=%b want=10", {pc_en, bus.imem_req_o});
        end else passed++;
        @(negedge clk);
        #1;
        total++;
        if ({pc_en, bus.imem_req_o, bus.imem_addr_o} !== {2'b01, 32'h0}) begin
            $display("FAIL first_req got en=%b req=%b addr=%h want 0/1/00000000",
                     pc_en, bus.imem_req_o, bus.imem_addr_o);
        end else passed++;
    endtask

    task automatic test_zero_wait();
        bus.imem_ack_i = 1'b1;
        bus.imem_rdata_i = 32'h0050_0093;
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        #1;
        total++;
        if ({bus.inst_valid_o, bus.imem_req_o} !== 2'b10) begin
            $display("FAIL zw_valid got=%b want=10", {bus.inst_valid_o, bus.imem_req_o});
        end else passed++;
        total++;
        if ({bus.inst_o, bus.inst_pc_o} !== {32'h0050_0093, 32'h0}) begin
            $display("FAIL zw_inst got=%h/%h want=00500093/00000000",
                     bus.inst_o, bus.inst_pc_o);
        end else passed++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            bus.id_ready_i = 1'b0;
            bus.imem_ack_i = 1'b1;
            bus.imem_rdata_i = 32'hDEAD_BEEF;
            #1;
            total++;
            if ({pc_en, bus.imem_req_o, bus.inst_valid_o, bus.inst_o} !==
                {3'b001, 32'h0050_0093}) begin
                $display("FAIL stall_%0d got en=%b req=%b v=%b inst=%h",
                         i, pc_en, bus.imem_req_o, bus.inst_valid_o, bus.inst_o);
            end else passed++;
        end
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        bus.id_ready_i = 1'b1;
        #1;
        total++;
        if (pc_en !== 1'b1) begin
            $display("FAIL consume_pc_en got=%b want=1", pc_en);
        end else passed++;
        @(negedge clk);
        bus.id_ready_i = 1'b0;
        #1;
        total++;
        if ({bus.imem_req_o, bus.inst_valid_o, bus.imem_addr_o} !== {2'b10, 32'h4}) begin
            $display("FAIL next_req got req=%b v=%b addr=%h want 1/0/00000004",
                     bus.imem_req_o, bus.inst_valid_o, bus.imem_addr_o);
        end else passed++;
    endtask

    task automatic test_wait_states();
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                bus.imem_ack_i = 1'b1;
                bus.imem_rdata_i = 32'h0020_8233;
            end
            #1;
            total++;
            if ({bus.imem_req_o, bus_err, pc_en, bus.imem_addr_o} !== {3'b100, 32'h4}) begin
                $display("FAIL wait_%0d got req=%b err=%b en=%b addr=%h",
                         i, bus.imem_req_o, bus_err, pc_en, bus.imem_addr_o);
            end else passed++;
        end
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        #1;
        total++;
        if ({bus.inst_valid_o, bus_err, bus.inst_o, bus.inst_pc_o} !==
            {2'b10, 32'h0020_8233, 32'h4}) begin
            $display("FAIL wait_done got v=%b err=%b inst=%h pc=%h",
                     bus.inst_valid_o, bus_err, bus.inst_o, bus.inst_pc_o);
        end else passed++;
        bus.id_ready_i = 1'b1;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.id_ready_i = 1'b0;
            #1;
            total++;
            if ({bus.imem_req_o, bus_err, bus.imem_addr_o} !== {2'b10, 32'h8}) begin
                $display("FAIL to_wait_%0d got req=%b err=%b addr=%h",
                         i, bus.imem_req_o, bus_err, bus.imem_addr_o);
            end else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.imem_ack_i = (i > 0);
            bus.imem_rdata_i = 32'h1111_1111;
            #1;
            total++;
            if ({bus_err, bus.imem_req_o, pc_en, bus.inst_valid_o} !== 4'b1000) begin
                $display("FAIL err_hold_%0d got=%b want=1000",
                         i, {bus_err, bus.imem_req_o, pc_en, bus.inst_valid_o});
            end else passed++;
        end
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_err, bus.imem_req_o} !== 2'b00) begin
            $display("FAIL err_reset got=%b want=00", {bus_err, bus.imem_req_o});
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({pc_en, bus.imem_req_o} !== 2'b10) begin
            $display("FAIL reboot got=%b want=10", {pc_en, bus.imem_req_o});
        end else passed++;
    endtask

    task automatic test_ack_at_timeout();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                bus.imem_ack_i = 1'b1;
                bus.imem_rdata_i = 32'h0030_0213;
            end
            #1;
            total++;
            if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0}) begin
                $display("FAIL late_wait_%0d got req=%b addr=%h",
                         i, bus.imem_req_o, bus.imem_addr_o);
            end else passed++;
        end
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        #1;
        total++;
        if ({bus_err, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o} !==
            {2'b01, 32'h0030_0213, 32'h0}) begin
            $display("FAIL ack_wins got err=%b v=%b inst=%h pc=%h",
                     bus_err, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
        end else passed++;
    endtask

    task automatic test_misalign();
        logic [31:0] exp_inst;
        logic        exp_mis;
        logic        exp_req;
`ifdef IFETCH_MISALIGN_CHK_EN
        exp_inst = 32'h0000_0013;
        exp_mis  = 1'b1;
        exp_req  = 1'b0;
`else
        exp_inst = 32'h0010_0113;
        exp_mis  = 1'b0;
        exp_req  = 1'b1;
`endif
        bus.id_ready_i = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 32'h0000_0006;
        @(negedge clk);
        bus.id_ready_i = 1'b0;
        pc_load = 1'b0;
        bus.imem_ack_i = 1'b1;
        bus.imem_rdata_i = 32'h0010_0113;
        #1;
        total++;
        if ({bus.imem_req_o, bus.imem_addr_o} !== {exp_req, 32'h4}) begin
            $display("FAIL mis_req got req=%b addr=%h want %b/00000004",
                     bus.imem_req_o, bus.imem_addr_o, exp_req);
        end else passed++;
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        #1;
        total++;
        if ({bus.inst_valid_o, misalign, bus.inst_o, bus.inst_pc_o} !==
            {1'b1, exp_mis, exp_inst, 32'h6}) begin
            $display("FAIL mis_inst got v=%b mis=%b inst=%h pc=%h want 1/%b/%h/00000006",
                     bus.inst_valid_o, misalign, bus.inst_o, bus.inst_pc_o,
                     exp_mis, exp_inst);
        end else passed++;
        bus.id_ready_i = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 32'h0000_0010;
        @(negedge clk);
        bus.id_ready_i = 1'b0;
        pc_load = 1'b0;
        bus.imem_ack_i = 1'b1;
        bus.imem_rdata_i = 32'h0020_0193;
        #1;
        total++;
        if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h10}) begin
            $display("FAIL realign_req got req=%b addr=%h want 1/00000010",
                     bus.imem_req_o, bus.imem_addr_o);
        end else passed++;
        @(negedge clk);
        bus.imem_ack_i = 1'b0;
        #1;
        total++;
        if ({misalign, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o} !==
            {2'b01, 32'h0020_0193, 32'h10}) begin
            $display("FAIL mis_clear got mis=%b v=%b inst=%h pc=%h",
                     misalign, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_states();
        test_timeout();
        test_ack_at_timeout();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
